// File: rtl/reaction_delay_timer.sv
// Random-delay / reaction timer: waits a LFSR-derived number of ms after a start edge,
// raises time_out, then counts the player's reaction in BCD ms until stop.
module reaction_delay_timer #(
  parameter int LFSR_W    = 7,
  parameter int DELAY_MIN = 250,
  parameter int SCALE_SH  = 4,
  parameter int CNT_W     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_ms,
  input  logic              start_delay,
  input  logic [LFSR_W-1:0] lfsr_val,
  input  logic              stop,
  output logic              time_out,
  output logic              busy,
  output logic [15:0]       result_bcd,
  output logic              result_valid,
  output logic              early,
  output logic              overflow
);

  localparam logic [4:0] S_IDLE        = 5'b00001;
  localparam logic [4:0] S_DELAY       = 5'b00010;
  localparam logic [4:0] S_REACT       = 5'b00100;
  localparam logic [4:0] S_DONE        = 5'b01000;
  localparam logic [4:0] S_FALSE_START = 5'b10000;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  logic [4:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             start_prev;
  logic             start_edge;
  logic [CNT_W-1:0] delay_load;
  logic [15:0]      bcd_plus1;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    start_edge = start_delay & ~start_prev;
    delay_load = CNT_W'(DELAY_MIN) + (CNT_W'(lfsr_val) << SCALE_SH);
    bcd_plus1  = bcd_inc(result_bcd);
  end

  // Flags are pure state decodes, so an illegal state (forced back to IDLE) reads as all-zero.
  assign busy         = (state == S_DELAY) | (state == S_REACT);
  assign time_out     = (state == S_REACT) | (state == S_DONE);
  assign result_valid = (state == S_DONE)  | (state == S_FALSE_START);
  assign early        = (state == S_FALSE_START);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      start_prev <= 1'b1;
      result_bcd <= '0;
      overflow   <= 1'b0;
    end else begin
      start_prev <= start_delay;
      case (state)
        S_IDLE, S_DONE, S_FALSE_START: begin
          if (start_edge) begin
            state      <= S_DELAY;
            cnt        <= delay_load;
            result_bcd <= '0;
            overflow   <= 1'b0;
          end
        end
        S_DELAY: begin
          if (stop) begin
            state      <= S_FALSE_START;
            result_bcd <= '0;
          end else if (tick_ms) begin
            // A zero load is treated like a final tick rather than wrapping the counter.
            if (cnt <= CNT_W'(1)) begin
              state      <= S_REACT;
              cnt        <= '0;
              result_bcd <= '0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        S_REACT: begin
          if (stop) begin
            state <= S_DONE;
          end else if (tick_ms) begin
            result_bcd <= bcd_plus1;
            if (bcd_plus1 == BCD_MAX) begin
              state    <= S_DONE;
              overflow <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
